// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer control stage.
package timer_pkg;

  // Timer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Encodings of the latched mode bit.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter.sv
// Loadable up-counter driven by timer_ctrl; load has priority over enab.
module counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  // Count register: load a start value or step by one, wrapping modulo 2^WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_out <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_out <= cnt_in;
    end else if (enab) begin
      cnt_out <= cnt_out + WIDTH'(1);
    end else begin
      cnt_out <= cnt_out;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Prescaler: counts RUN cycles and flags a tick every presc_q+1 cycles.
module tick_gen #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          run,
  input  logic [PW-1:0] presc_q,
  output logic          tick
);

  logic [PW-1:0] presc_cnt_q;
  logic [PW-1:0] presc_cnt_d;

  assign tick = run && (presc_cnt_q == presc_q);

  // Next prescaler count: clear outside RUN, wrap to zero on a tick.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clr) begin
      presc_cnt_d = {PW{1'b0}};
    end else if (run) begin
      if (tick) begin
        presc_cnt_d = {PW{1'b0}};
      end else begin
        presc_cnt_d = presc_cnt_q + PW'(1);
      end
    end else begin
      presc_cnt_d = presc_cnt_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= {PW{1'b0}};
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer control stage: arms, prescales and reloads an external up-counter and
// pulses expired once per terminal tick.
import timer_pkg::*;

module timer_ctrl #(
  parameter int WIDTH = 5,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] reload_val,
  input  logic [WIDTH-1:0] period,
  input  logic [PW-1:0]    presc,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             expired,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic             mode_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] period_q;
  logic [PW-1:0]    presc_q;
  logic             expired_q;

  logic             tick;
  logic             term;
  logic             in_run;
  logic             presc_clr;

  assign in_run    = (state_q == RUN);
  assign presc_clr = !in_run;
  assign term      = tick && (cnt_val == period_q);
  assign cnt_in    = reload_q;
  assign expired   = expired_q;

  tick_gen #(.PW(PW)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (presc_clr),
    .run     (in_run),
    .presc_q (presc_q),
    .tick    (tick)
  );

  // Counter strobes and status; stop masks every strobe in the same cycle.
  always_comb begin
    load = 1'b0;
    enab = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        busy = 1'b1;
        if (stop) begin
          load = 1'b0;
        end else begin
          load = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (stop) begin
          load = 1'b0;
          enab = 1'b0;
        end else if (term) begin
          load = (mode_q == MODE_PERIODIC);
          enab = 1'b0;
        end else begin
          load = 1'b0;
          enab = tick;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Control FSM with configuration capture on each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      reload_q <= {WIDTH{1'b0}};
      period_q <= {WIDTH{1'b0}};
      presc_q  <= {PW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            mode_q   <= mode;
            reload_q <= reload_val;
            period_q <= period;
            presc_q  <= presc;
            state_q  <= LOAD;
          end else begin
            state_q  <= IDLE;
          end
        end
        LOAD: begin
          if (stop) begin
            state_q <= IDLE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (term && (mode_q == MODE_ONESHOT)) begin
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (start) begin
            mode_q   <= mode;
            reload_q <= reload_val;
            period_q <= period;
            presc_q  <= presc;
            state_q  <= LOAD;
          end else begin
            state_q  <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Expiry pulse follows an unaborted terminal tick by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expired_q <= 1'b0;
    end else begin
      expired_q <= in_run && term && !stop;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized scoreboard bench for timer_ctrl driving a loadable counter.
module tb_timer_ctrl;

  localparam int W  = 5;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  reload_val = '0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  cnt_val;
  logic [W-1:0]  cnt_in;
  logic          load, enab, expired, busy, done;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // kind 0: at the stop cycle, kind 1: idle after stop, kind 2: under reset
  typedef struct {
    int           cyc;
    int           kind;
    bit           exp_done;
    bit           chk_cnt;
    logic [W-1:0] exp_cnt;
  } stat_t;

  int    expq[$];
  stat_t stq[$];

  timer_ctrl #(.WIDTH(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .reload_val(reload_val), .period(period), .presc(presc),
    .cnt_val(cnt_val), .load(load), .enab(enab), .cnt_in(cnt_in),
    .expired(expired), .busy(busy), .done(done)
  );

  counter #(.WIDTH(W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .enab(enab),
    .cnt_in(cnt_in), .cnt_out(cnt_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares expiry pulses and scheduled status checks.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0] < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missed_expiry cycle=%0d actual=none expected_at=%0d", cyc, expq[0]);
      void'(expq.pop_front());
    end
    if (expired) begin
      n_vec++;
      if (expq.size() > 0 && expq[0] == cyc) begin
        void'(expq.pop_front());
      end else begin
        n_err++;
        $display("FAIL unexpected_expiry cycle=%0d actual=1 expected=%0d",
                 cyc, (expq.size() > 0) ? expq[0] : -1);
      end
    end
    if (stq.size() > 0 && stq[0].cyc == cyc) begin
      stat_t s;
      s = stq.pop_front();
      case (s.kind)
        0: begin
          chk("stop_strobes", {30'd0, load, enab}, 0);
          chk("stop_busy_done", {30'd0, busy, done}, {30'd0, !s.exp_done, s.exp_done});
          if (s.chk_cnt) chk("stop_cnt_val", int'(cnt_val), int'(s.exp_cnt));
        end
        1: begin
          chk("idle_status", {29'd0, busy, done, load}, 0);
          chk("pending_expiries", expq.size(), 0);
        end
        default: begin
          chk("reset_outputs", {27'd0, load, enab, busy, done, expired}, 0);
          chk("reset_cnt_in", int'(cnt_in), 0);
        end
      endcase
    end
  end

  // One timer run: arm with a config, optionally retry start mid-run, stop at offset sc.
  task automatic run_scn(input int p, input int rl, input int pd, input int md,
                         input int sc, input int ign);
    int    s0, tt, tp, e, m;
    stat_t st;
    @(posedge clk); #1;
    s0 = cyc;
    presc = PW'(p); reload_val = W'(rl); period = W'(pd); mode = md[0];
    start = 1'b1;
    tt = ((pd - rl) % 32 + 32) % 32 + 1;
    tp = tt * (p + 1);
    e = s0 + tp + 2;
    while (e <= s0 + sc) begin
      expq.push_back(e);
      if (md == 0) break;
      e += tp;
    end
    st.cyc = s0 + sc;
    st.kind = 0;
    st.exp_done = (md == 0) && (sc >= tp + 2);
    st.chk_cnt = (sc >= 2);
    if (st.exp_done) begin
      st.exp_cnt = W'(pd);
    end else begin
      m = (md != 0) ? (sc - 2) % tp : sc - 2;
      if (m < 0) m = 0;
      st.exp_cnt = W'((rl + m / (p + 1)) % 32);
    end
    stq.push_back(st);
    st.cyc = s0 + sc + 2;
    st.kind = 1;
    stq.push_back(st);
    for (int i = 1; i <= sc; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      reload_val = W'($urandom);
      period = W'($urandom);
      presc = PW'($urandom);
      mode = 1'($urandom);
      if (i == ign) start = 1'b1;
      if (i == sc) stop = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    stat_t st;
    int    s0, p, rl, pd, md, sc, ign, tp;
    st.cyc = 1; st.kind = 2; st.exp_done = 1'b0; st.chk_cnt = 1'b0; st.exp_cnt = '0;
    stq.push_back(st);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_scn(0, 0, 3, 1, 20, 3);
    run_scn(0, 0, 3, 1, 17, 0);
    run_scn(2, 1, 2, 0, 12, 0);
    run_scn(0, 30, 1, 1, 15, 0);
    run_scn(0, 7, 7, 1, 8, 0);
    run_scn(0, 7, 7, 0, 5, 0);

    // start and stop together while idle
    @(posedge clk); #1;
    presc = 4'd0; reload_val = 5'd0; period = 5'd3; mode = 1'b1;
    start = 1'b1; stop = 1'b1;
    st.cyc = cyc + 1; st.kind = 1;
    stq.push_back(st);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);

    // asynchronous reset between clock edges in the middle of RUN
    @(posedge clk); #1;
    s0 = cyc;
    presc = 4'd0; reload_val = 5'd0; period = 5'd3; mode = 1'b1; start = 1'b1;
    expq.push_back(s0 + 6);
    st.cyc = s0 + 8; st.kind = 2;
    stq.push_back(st);
    st.cyc = s0 + 10; st.kind = 1;
    stq.push_back(st);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_scn(0, 0, 3, 1, 12, 0);

    for (int k = 0; k < 22; k++) begin
      p  = $urandom_range(7, 0);
      rl = $urandom_range(31, 0);
      pd = $urandom_range(31, 0);
      md = $urandom_range(1, 0);
      tp = ((((pd - rl) % 32 + 32) % 32) + 1) * (p + 1);
      sc = $urandom_range(2 * tp + 4, 1);
      ign = (sc > 2 && $urandom_range(1, 0) == 1) ? $urandom_range(sc - 1, 1) : 0;
      if (md == 0 && ign >= tp + 2) ign = 0;
      run_scn(p, rl, pd, md, sc, ign);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
